seg7_readback_monitor: RTL and testbench

//  Receive-side checker for the two-digit 7-segment display bus driven by the 0-99 up-counter.

---
 rtl/seg7_readback_monitor.sv | 141 ++++++++++++++
 tb/tb_seg7_readback_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback_monitor.sv
// Receive-side checker for a two-digit active-low 7-segment bus driven by a 0-99 counter.
// Debounces sampled patterns, decodes them to BCD and flags non-incrementing steps.
module seg7_readback_monitor #(
  parameter int STABLE_N = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [6:0]       seg7_units,
  input  logic [6:0]       seg7_tens,
  output logic [3:0]       bcd_units,
  output logic [3:0]       bcd_tens,
  output logic             value_valid,
  output logic             change_pulse,
  output logic             step_error,
  output logic             invalid_pattern,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_N);

  // Returns {legal, digit}; anything outside the ten digit shapes is illegal.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return 5'd0;
    endcase
  endfunction

  // Two-digit BCD increment with 99 -> 00 wrap, result as {tens, units}.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units);
    if (units == 4'd9) begin
      if (tens == 4'd9) return 8'h00;
      return {tens + 4'd1, 4'd0};
    end
    return {tens, units + 4'd1};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (&val) return val;
    return val + 1'b1;
  endfunction

  logic [1:0]  state;
  logic [13:0] last_raw;
  logic [13:0] committed_raw;
  logic [3:0]  stab_cnt;
  logic        primed;

  logic [13:0] raw;
  logic [3:0]  cnt_next;
  logic        stable;
  logic        commit;
  logic        settle_back;
  logic [4:0]  dec_units;
  logic [4:0]  dec_tens;
  logic        legal;
  logic [7:0]  new_bcd;
  logic        step_bad;

  always_comb begin
    raw = {seg7_tens, seg7_units};
    if (raw != last_raw)
      cnt_next = 4'd1;
    else if (stab_cnt >= STABLE_MAX)
      cnt_next = STABLE_MAX;
    else
      cnt_next = stab_cnt + 4'd1;
    stable      = (cnt_next == STABLE_MAX);
    // primed distinguishes "nothing committed yet" so an all-zero raw word can still commit first.
    commit      = sample_en && stable && (!primed || raw != committed_raw);
    settle_back = primed && stable && (raw == committed_raw);
    dec_units   = decode(seg7_units);
    dec_tens    = decode(seg7_tens);
    legal       = dec_units[4] && dec_tens[4];
    new_bcd     = {dec_tens[3:0], dec_units[3:0]};
    step_bad    = value_valid && (new_bcd != bcd_inc(bcd_tens, bcd_units)) && (new_bcd != 8'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_EMPTY;
      last_raw        <= '0;
      committed_raw   <= '0;
      stab_cnt        <= '0;
      primed          <= 1'b0;
      bcd_units       <= '0;
      bcd_tens        <= '0;
      value_valid     <= 1'b0;
      change_pulse    <= 1'b0;
      step_error      <= 1'b0;
      invalid_pattern <= 1'b0;
      err_count       <= '0;
    end else begin
      change_pulse    <= 1'b0;
      step_error      <= 1'b0;
      invalid_pattern <= 1'b0;
      if (sample_en) begin
        last_raw <= raw;
        stab_cnt <= cnt_next;
        case (state)
          S_EMPTY:  state <= S_SETTLE;
          S_SETTLE: if (commit || settle_back) state <= S_LOCKED;
          S_LOCKED: if (raw != committed_raw) state <= S_SETTLE;
          default:  state <= S_EMPTY;
        endcase
        if (commit) begin
          committed_raw <= raw;
          primed        <= 1'b1;
          if (legal) begin
            bcd_units    <= dec_units[3:0];
            bcd_tens     <= dec_tens[3:0];
            value_valid  <= 1'b1;
            change_pulse <= 1'b1;
            step_error   <= step_bad;
            if (step_bad) err_count <= sat_inc(err_count);
          end else begin
            value_valid     <= 1'b0;
            invalid_pattern <= 1'b1;
            err_count       <= sat_inc(err_count);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_readback_monitor.sv
// Scoreboard bench: directed digit sequences push expected commit events; a monitor pops on each pulse.
module tb_seg7_readback_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [6:0] seg_u;
  logic [6:0] seg_t;

  logic [3:0] bcd_units, bcd_tens;
  logic       value_valid, change_pulse, step_error, invalid_pattern;
  logic [7:0] err_count;

  logic [3:0] d2_bcd_units, d2_bcd_tens;
  logic       d2_value_valid, d2_change_pulse, d2_step_error, d2_invalid_pattern;
  logic [1:0] d2_err_count;

  int checks   = 0;
  int failures = 0;
  int change_count = 0;

  typedef struct {
    logic [3:0] t;
    logic [3:0] u;
    logic       cp;
    logic       vv;
    logic       se;
    logic       ip;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  seg7_readback_monitor #(.STABLE_N(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .seg7_units(seg_u), .seg7_tens(seg_t),
    .bcd_units(bcd_units), .bcd_tens(bcd_tens), .value_valid(value_valid),
    .change_pulse(change_pulse), .step_error(step_error),
    .invalid_pattern(invalid_pattern), .err_count(err_count)
  );

  seg7_readback_monitor #(.STABLE_N(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .seg7_units(seg_u), .seg7_tens(seg_t),
    .bcd_units(d2_bcd_units), .bcd_tens(d2_bcd_tens), .value_valid(d2_value_valid),
    .change_pulse(d2_change_pulse), .step_error(d2_step_error),
    .invalid_pattern(d2_invalid_pattern), .err_count(d2_err_count)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Monitor: every pulse must match the oldest expected commit event.
  always @(negedge clk) begin
    if (!reset && (change_pulse || step_error || invalid_pattern)) begin
      if (change_pulse) change_count++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual cp=%0b se=%0b ip=%0b bcd=%0d%0d required no pulse",
                 change_pulse, step_error, invalid_pattern, bcd_tens, bcd_units);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bcd_tens !== e.t || bcd_units !== e.u || change_pulse !== e.cp ||
            value_valid !== e.vv || step_error !== e.se || invalid_pattern !== e.ip ||
            err_count !== e.ec) begin
          failures++;
          $display("FAIL scoreboard actual bcd=%0d%0d cp=%0b vv=%0b se=%0b ip=%0b ec=%0d required bcd=%0d%0d cp=%0b vv=%0b se=%0b ip=%0b ec=%0d",
                   bcd_tens, bcd_units, change_pulse, value_valid, step_error, invalid_pattern, err_count,
                   e.t, e.u, e.cp, e.vv, e.se, e.ip, e.ec);
        end
      end
    end
  end

  task automatic expect_ev(input int t, input int u, input bit cp, input bit vv,
                           input bit se, input bit ip, input int ec);
    exp_t e;
    e.t = 4'(t); e.u = 4'(u); e.cp = cp; e.vv = vv; e.se = se; e.ip = ip; e.ec = 8'(ec);
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [6:0] t, input logic [6:0] u, input int n);
    repeat (n) begin
      @(negedge clk);
      seg_t = t; seg_u = u; sample_en = 1'b1;
    end
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic hold_val(input int v, input int n);
    drive(seg(v / 10), seg(v % 10), n);
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #1;
    chk(name, q.size(), 0);
    q.delete();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_bcd"}, {bcd_tens, bcd_units}, 0);
    chk({name, "_flags"}, {value_valid, change_pulse, step_error, invalid_pattern}, 0);
    chk({name, "_err"}, err_count, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; seg_u = 7'h7f; seg_t = 7'h7f;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("reset_state");

    // T1: first commit, then an out-of-step value, then async reset mid-cycle
    expect_ev(0, 0, 1, 1, 0, 0, 0);
    hold_val(0, 4);
    drain("t1_first_commit");
    expect_ev(0, 5, 1, 1, 1, 0, 1);
    hold_val(5, 4);
    drain("t1_step");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero("t1_async_reset");
    @(negedge clk);
    reset = 1'b0;
    change_count = 0;

    // T2: full count 00..99 then wrap to 00
    for (int v = 0; v < 100; v++) begin
      expect_ev(v / 10, v % 10, 1, 1, 0, 0, 0);
      hold_val(v, 4);
    end
    expect_ev(0, 0, 1, 1, 0, 0, 0);
    hold_val(0, 4);
    drain("t2_drain");
    chk("t2_change_count", change_count, 101);
    chk("t2_err_count", err_count, 0);

    // T3: 05 -> 07 is a step error
    pulse_reset();
    expect_ev(0, 5, 1, 1, 0, 0, 0);
    hold_val(5, 4);
    expect_ev(0, 7, 1, 1, 1, 0, 1);
    hold_val(7, 4);
    drain("t3_drain");
    chk("t3_bcd_units", bcd_units, 7);
    chk("t3_err_count", err_count, 1);

    // T4: invalid units pattern, then recovery without a step check
    expect_ev(0, 7, 0, 0, 0, 1, 2);
    drive(seg(4), 7'b0001000, 4);
    drain("t4_invalid");
    chk("t4_value_valid", value_valid, 0);
    chk("t4_bcd_held", {bcd_tens, bcd_units}, 8'h07);
    expect_ev(4, 2, 1, 1, 0, 0, 2);
    hold_val(42, 4);
    drain("t4_recover");

    // T5: short glitch must not commit
    pulse_reset();
    expect_ev(1, 2, 1, 1, 0, 0, 0);
    hold_val(12, 4);
    hold_val(13, 3);
    hold_val(12, 4);
    drain("t5_glitch");
    expect_ev(1, 3, 1, 1, 0, 0, 0);
    hold_val(13, 4);
    drain("t5_commit");

    // T6: five step errors saturate a 2-bit counter; reset beats a coincident sample
    pulse_reset();
    expect_ev(0, 0, 1, 1, 0, 0, 0);
    hold_val(0, 4);
    expect_ev(0, 5, 1, 1, 1, 0, 1);
    hold_val(5, 4);
    expect_ev(1, 0, 1, 1, 1, 0, 2);
    hold_val(10, 4);
    expect_ev(2, 0, 1, 1, 1, 0, 3);
    hold_val(20, 4);
    expect_ev(3, 0, 1, 1, 1, 0, 4);
    hold_val(30, 4);
    expect_ev(4, 0, 1, 1, 1, 0, 5);
    hold_val(40, 4);
    drain("t6_drain");
    chk("t6_err_count_w8", err_count, 5);
    chk("t6_err_count_w2_sat", d2_err_count, 3);

    @(negedge clk);
    seg_t = seg(4); seg_u = seg(1); sample_en = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("t6_reset_wins");
    chk("t6_w2_reset", d2_err_count, 0);
    @(negedge clk);
    sample_en = 1'b0; reset = 1'b0;
    hold_val(41, 3);
    drain("t6_history_cleared");
    expect_ev(4, 1, 1, 1, 0, 0, 0);
    hold_val(41, 1);
    drain("t6_commit_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
